// File: rtl/shape_processor_calc.sv
// Shape calculation engine: latches a shape/operation request, computes the result on a
// serial shift-add multiplier and returns it over valid/ready. Optional abort: SHAPE_PROCESSOR_CALC_ABORT_EN.
package shape_processor_modeling;
  typedef enum logic [1:0] {
    KEEP_SHAPE = 2'd0,
    CIRCLE     = 2'd1,
    RECTANGLE  = 2'd2,
    TRIANGLE   = 2'd3
  } shape_e;

  typedef enum logic [2:0] {
    KEEP_OPERATION = 3'd0,
    PERIMETER      = 3'd1,
    AREA           = 3'd2,
    IS_SQUARE      = 3'd3,
    IS_EQUILATERAL = 3'd4,
    IS_ISOSCELES   = 3'd5
  } operation_e;

  function automatic logic is_legal_combination(input shape_e s, input operation_e o);
    case (s)
      CIRCLE:    return (o == PERIMETER) || (o == AREA);
      RECTANGLE: return (o == PERIMETER) || (o == AREA) || (o == IS_SQUARE);
      TRIANGLE:  return (o == PERIMETER) || (o == AREA) || (o == IS_EQUILATERAL) ||
                        (o == IS_ISOSCELES);
      default:   return 1'b0;
    endcase
  endfunction
endpackage

// Handshake: result is transferred on any rising clk edge where result_valid && result_ready;
// result_valid stays high and result/error stay stable until that edge.
module shape_processor_calc #(
  parameter int DIM_W = 16,
  parameter int PI_Q8 = 804
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           shape,
  input  logic [2:0]           operation,
  input  logic [DIM_W-1:0]     dim_a,
  input  logic [DIM_W-1:0]     dim_b,
  input  logic [DIM_W-1:0]     dim_c,
  output logic                 busy,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [2*DIM_W+3:0]   result,
  output logic                 error
`ifdef SHAPE_PROCESSOR_CALC_ABORT_EN
  ,
  input  logic                 abort
`endif
);
  import shape_processor_modeling::*;

  localparam int RES_W = 2*DIM_W+4;
  localparam int ACC_W = 2*DIM_W+12;
  localparam int PI_W  = 12;
  localparam int CNT_W = $clog2(DIM_W+PI_W+1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  typedef enum logic [3:0] {
    K_ILLEGAL, K_C_PERIM, K_C_AREA, K_R_PERIM, K_R_AREA,
    K_R_SQ, K_T_PERIM, K_T_AREA, K_T_EQ, K_T_ISO
  } kind_e;

  state_e             state, state_nxt;
  kind_e              kind_in, kind_q;
  logic [CNT_W-1:0]   lat_in, cnt;
  logic [DIM_W-1:0]   a_q, b_q, c_q, mplier;
  logic [ACC_W-1:0]   acc, mcand, acc_step;
  logic [RES_W-1:0]   res_fin;
  logic               accept, abort_hit;
  shape_e             s_in;
  operation_e         o_in;

  assign s_in   = shape_e'(shape);
  assign o_in   = operation_e'(operation);
  assign accept = (state == S_IDLE) && start;
`ifdef SHAPE_PROCESSOR_CALC_ABORT_EN
  assign abort_hit = abort && (state != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    kind_in = K_ILLEGAL;
    if (is_legal_combination(s_in, o_in)) begin
      case (s_in)
        CIRCLE:    kind_in = (o_in == AREA) ? K_C_AREA : K_C_PERIM;
        RECTANGLE: kind_in = (o_in == PERIMETER) ? K_R_PERIM :
                             (o_in == AREA) ? K_R_AREA : K_R_SQ;
        TRIANGLE:  kind_in = (o_in == PERIMETER) ? K_T_PERIM :
                             (o_in == AREA) ? K_T_AREA :
                             (o_in == IS_EQUILATERAL) ? K_T_EQ : K_T_ISO;
        default:   kind_in = K_ILLEGAL;
      endcase
    end
  end

  always_comb begin
    case (kind_in)
      K_C_PERIM, K_R_AREA, K_T_AREA: lat_in = CNT_W'(DIM_W);
      K_C_AREA:                      lat_in = CNT_W'(DIM_W + PI_W);
      default:                       lat_in = CNT_W'(1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_CALC;
      S_CALC: begin
        if (abort_hit)     state_nxt = S_IDLE;
        else if (cnt == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (abort_hit || result_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign acc_step = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    res_fin = '0;
    case (kind_q)
      K_C_PERIM, K_C_AREA: res_fin = acc[8 +: RES_W];
      K_R_AREA:            res_fin = acc[RES_W-1:0];
      K_T_AREA:            res_fin = acc[1 +: RES_W];
      K_R_PERIM:           res_fin = (RES_W'(a_q) + RES_W'(b_q)) << 1;
      K_T_PERIM:           res_fin = RES_W'(a_q) + RES_W'(b_q) + RES_W'(c_q);
      K_R_SQ:              res_fin = RES_W'(a_q == b_q);
      K_T_EQ:              res_fin = RES_W'((a_q == b_q) && (b_q == c_q));
      K_T_ISO:             res_fin = RES_W'((a_q == b_q) || (b_q == c_q) || (a_q == c_q));
      default:             res_fin = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q <= K_ILLEGAL;
      a_q <= '0; b_q <= '0; c_q <= '0;
      acc <= '0; mcand <= '0; mplier <= '0; cnt <= '0;
      busy <= 1'b0; result_valid <= 1'b0; result <= '0; error <= 1'b0;
    end else begin
      busy <= (state != S_IDLE) && (state_nxt != S_IDLE);
      if (accept) begin
        kind_q <= kind_in;
        a_q <= dim_a; b_q <= dim_b; c_q <= dim_c;
        acc <= '0;
        cnt <= lat_in;
        case (kind_in)
          K_C_PERIM:          begin mcand <= ACC_W'(2*PI_Q8); mplier <= dim_a; end
          K_C_AREA:           begin mcand <= ACC_W'(dim_a);   mplier <= dim_a; end
          K_R_AREA, K_T_AREA: begin mcand <= ACC_W'(dim_b);   mplier <= dim_a; end
          default:            begin mcand <= '0;              mplier <= '0;    end
        endcase
      end else if (abort_hit) begin
        result_valid <= 1'b0;
        result <= '0;
        error <= 1'b0;
      end else if (state == S_CALC) begin
        if (cnt != '0) begin
          cnt    <= cnt - 1'b1;
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          // Circle area: a*a is complete after DIM_W passes; reload to multiply it by pi.
          if (kind_q == K_C_AREA && cnt == CNT_W'(PI_W + 1)) begin
            acc    <= '0;
            mcand  <= acc_step;
            mplier <= DIM_W'(PI_Q8);
          end
        end else begin
          result       <= res_fin;
          error        <= (kind_q == K_ILLEGAL);
          result_valid <= 1'b1;
        end
      end else if (state == S_DONE && result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end
endmodule
